// File: rtl/memory_access.sv
// Pipeline memory-access stage: issues one data-memory request per load/store,
// waits for dmem_ready, extracts/extends load data and faults on misaligned or illegal accesses.
module memory_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_stall,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state;
    state_t state_next;

    logic            is_mem;
    logic            is_load;
    logic            illegal;
    logic            misaligned;
    logic            fault;
    logic            accept_mem;
    logic            complete;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rshift;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_data;

    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic [3:0]      lat_be;
    logic            lat_we;
    logic [RW-1:0]   lat_rd;
    logic [2:0]      lat_f3;
    logic            lat_rw;

    // Request decode; a read+write combination is handled as a plain load
    always_comb begin
        is_mem  = mem_read | mem_write;
        is_load = mem_read;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = ~is_load;
            default:                illegal = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        fault      = (state == IDLE) && ex_valid && is_mem && (illegal || misaligned);
        accept_mem = (state == IDLE) && ex_valid && is_mem && !(illegal || misaligned);
        complete   = (state == BUSY) && dmem_ready;
    end

    // Store lane steering; loads carry no byte enables
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = rs2_data;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_result[1:0];
                wdata_c = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {alu_result[1], 1'b0};
                wdata_c = {2{rs2_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rs2_data;
            end
        endcase
        if (is_load) begin
            be_c = 4'b0000;
        end
    end

    // Load lane select and extension from the latched address/size
    always_comb begin
        rshift    = dmem_rdata >> {lat_addr[1:0], 3'b000};
        load_byte = rshift[7:0];
        load_half = lat_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'h000000, load_byte};
            3'b101:  load_data = {16'h0000, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mem) state_next = BUSY;
            BUSY:    if (dmem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        dmem_req  = 1'b0;
        if (state == BUSY) begin
            mem_stall = 1'b1;
            dmem_req  = 1'b1;
        end
    end

    assign dmem_we    = lat_we;
    assign dmem_addr  = lat_addr;
    assign dmem_wdata = lat_wdata;
    assign dmem_be    = lat_be;

    // Access context captured on acceptance, held stable for the whole BUSY period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_we    <= 1'b0;
            lat_rd    <= '0;
            lat_f3    <= '0;
            lat_rw    <= 1'b0;
        end else if (accept_mem) begin
            lat_addr  <= alu_result;
            lat_wdata <= wdata_c;
            lat_be    <= be_c;
            lat_we    <= ~is_load;
            lat_rd    <= rd_in;
            lat_f3    <= funct3;
            lat_rw    <= reg_write_in;
        end else if (complete) begin
            lat_we    <= 1'b0;
        end
    end

    // Writeback-side registers; valid/write/error strobes default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            misalign_err   <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            reg_write_out <= 1'b0;
            misalign_err  <= 1'b0;
            if (fault) begin
                out_valid      <= 1'b1;
                misalign_err   <= 1'b1;
                mem_data_out   <= '0;
                alu_result_out <= alu_result;
                rd_out         <= rd_in;
                mem_read_out   <= 1'b0;
            end else if ((state == IDLE) && ex_valid && !is_mem) begin
                out_valid      <= 1'b1;
                mem_data_out   <= '0;
                alu_result_out <= alu_result;
                rd_out         <= rd_in;
                reg_write_out  <= reg_write_in;
                mem_read_out   <= 1'b0;
            end else if (complete) begin
                out_valid      <= 1'b1;
                mem_data_out   <= lat_we ? '0 : load_data;
                alu_result_out <= lat_addr;
                rd_out         <= lat_rd;
                reg_write_out  <= ~lat_we & lat_rw;
                mem_read_out   <= ~lat_we;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: expected writebacks are queued as each
// instruction is driven and compared when out_valid appears.
module tb_memory_access;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [31:0] mem_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_stall;
    logic        misalign_err;

    // mode: 0 = check all fields, 1 = store (no load data), 2 = fault (strobes only)
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    memory_access dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .rs2_data       (rs2_data),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ready     (dmem_ready),
        .dmem_rdata     (dmem_rdata),
        .out_valid      (out_valid),
        .mem_data_out   (mem_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_read_out   (mem_read_out),
        .mem_stall      (mem_stall),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every out_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.mode == 2'd0) check("mem_data_out", mem_data_out, e.data);
                if (e.mode != 2'd2) begin
                    check("alu_result_out", alu_result_out, e.alu);
                    check("rd_out", 32'(rd_out), 32'(e.rd));
                    check("mem_read_out", 32'(mem_read_out), 32'(e.mr));
                end
                check("reg_write_out", 32'(reg_write_out), 32'(e.rw));
                check("misalign_err", 32'(misalign_err), 32'(e.err));
            end
        end
    end

    task automatic alu_op(input logic [31:0] a, input logic [4:0] rd, input logic rw);
        exp_t e;
        e = '{mode: 2'd0, data: 32'h0, alu: a, rd: rd, rw: rw, mr: 1'b0, err: 1'b0};
        q.push_back(e);
        ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = a; rd_in = rd; reg_write_in = rw; funct3 = 3'b000;
        tick;
        ex_valid = 1'b0;
        check("alu_stall", 32'(mem_stall), 32'd0);
        check("alu_req", 32'(dmem_req), 32'd0);
    endtask

    task automatic mem_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                          input logic [4:0] rd, input int waits, input logic pulse,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_ld);
        exp_t e;
        e.mode = rd_en ? 2'd0 : 2'd1;
        e.data = rd_en ? exp_ld : 32'h0;
        e.alu  = addr;
        e.rd   = rd;
        e.rw   = rd_en;
        e.mr   = rd_en;
        e.err  = 1'b0;
        q.push_back(e);
        ex_valid = 1'b1; mem_read = rd_en; mem_write = wr_en; funct3 = f3;
        alu_result = addr; rs2_data = wd; rd_in = rd; reg_write_in = 1'b1;
        tick;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_result = 32'hDEAD_0000; rs2_data = ~wd; funct3 = 3'b111;
        check("accept_out_valid", 32'(out_valid), 32'd0);
        check("accept_reg_write", 32'(reg_write_out), 32'd0);
        for (int i = 0; i <= waits; i++) begin
            if (pulse && i == 0) begin
                ex_valid = 1'b1; alu_result = 32'h0000_5555; rd_in = 5'd1;
            end
            check("busy_req", 32'(dmem_req), 32'd1);
            check("busy_stall", 32'(mem_stall), 32'd1);
            check("busy_we", 32'(dmem_we), 32'(wr_en & ~rd_en));
            check("busy_addr", dmem_addr, addr);
            if (wr_en && !rd_en) begin
                check("busy_be", 32'(dmem_be), 32'(exp_be));
                check("busy_wdata", dmem_wdata, exp_wd);
            end
            if (i == waits) begin
                dmem_ready = 1'b1; dmem_rdata = rdat;
            end
            tick;
            ex_valid = 1'b0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
        end
        check("done_req", 32'(dmem_req), 32'd0);
        check("done_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic fault_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [4:0] rd);
        exp_t e;
        e = '{mode: 2'd2, data: 32'h0, alu: addr, rd: rd, rw: 1'b0, mr: 1'b0, err: 1'b1};
        q.push_back(e);
        ex_valid = 1'b1; mem_read = rd_en; mem_write = wr_en; funct3 = f3;
        alu_result = addr; rs2_data = 32'h1111_2222; rd_in = rd; reg_write_in = 1'b1;
        tick;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        check("fault_req", 32'(dmem_req), 32'd0);
        check("fault_stall", 32'(mem_stall), 32'd0);
        check("fault_err", 32'(misalign_err), 32'd1);
        tick;
        check("fault_err_clear", 32'(misalign_err), 32'd0);
        check("fault_req_after", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; rs2_data = '0; rd_in = '0;
        reg_write_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_alu_out", alu_result_out, 32'd0);
        check("rst_ctl", 32'({rd_out, reg_write_out, mem_read_out, misalign_err}), 32'd0);
        rst_n = 1'b1;
        tick;

        alu_op(32'h0000_1234, 5'd5, 1'b1);
        alu_op(32'h0000_0BEE, 5'd31, 1'b0);
        tick;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_reg_write", 32'(reg_write_out), 32'd0);
        check("idle_hold_alu", alu_result_out, 32'h0000_0BEE);

        // LB at lane 3, ready on the third BUSY cycle
        mem_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd7, 2, 1'b0,
               4'b0000, 32'h0, 32'hFFFF_FF80);
        mem_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 5'd9, 0, 1'b0,
               4'b1100, 32'hBEEF_BEEF, 32'h0);
        fault_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 5'd3);

        // Reset while BUSY; a late dmem_ready must not complete anything
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0200; rd_in = 5'd4; reg_write_in = 1'b1;
        tick;
        ex_valid = 1'b0; mem_read = 1'b0;
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(dmem_req), 32'd0);
        check("async_rst_stall", 32'(mem_stall), 32'd0);
        check("async_rst_alu_out", alu_result_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h1234_5678;
        tick;
        tick;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        check("post_rst_req", 32'(dmem_req), 32'd0);
        check("post_rst_stall", 32'(mem_stall), 32'd0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // SB with an ex_valid pulse during BUSY that must be ignored
        mem_op(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0, 5'd10, 2, 1'b1,
               4'b0010, 32'hA5A5_A5A5, 32'h0);
        mem_op(1'b1, 1'b0, 3'b101, 32'h0000_0400, 32'h0, 32'h0000_8001, 5'd11, 1, 1'b1,
               4'b0000, 32'h0, 32'h0000_8001);
        mem_op(1'b1, 1'b0, 3'b001, 32'h0000_0402, 32'h0, 32'h8001_1234, 5'd12, 0, 1'b0,
               4'b0000, 32'h0, 32'hFFFF_8001);
        mem_op(1'b1, 1'b1, 3'b100, 32'h0000_0007, 32'h5555_5555, 32'hF000_0000, 5'd13, 1, 1'b0,
               4'b0000, 32'h0, 32'h0000_00F0);
        mem_op(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 5'd14, 0, 1'b0,
               4'b1111, 32'hCAFE_F00D, 32'h0);
        mem_op(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h7654_3210, 5'd15, 0, 1'b0,
               4'b0000, 32'h0, 32'h7654_3210);
        alu_op(32'hFFFF_0001, 5'd2, 1'b1);

        fault_op(1'b0, 1'b1, 3'b001, 32'h0000_0203, 5'd16);
        fault_op(1'b0, 1'b1, 3'b100, 32'h0000_0000, 5'd17);
        fault_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 5'd18);

        tick;
        tick;
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
